seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
package seg_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}, dp off; entry i decodes nibble i.
  localparam logic [15:0][7:0] SEG_HEX_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Slot counter width; counts 0..div-1.
  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Shared hex-to-seven-segment decoder (active-low, dp excluded).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  assign seg7 = SEG_HEX_TABLE[nibble][6:0];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits.
// New display words are staged in a pending register and applied only at
// frame boundaries so the display never tears. Each digit slot starts with a
// blanked guard period to suppress ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blanks digits above the most
// significant non-zero nibble (digit 0 always shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);

  localparam int CW = cnt_width(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GLAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic [NUM_DIGITS-1:0][3:0] pend_q;
  logic                       pend_f;
  logic                       pend_f_nxt;
  logic                       accept;

  scan_state_t     state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;

  logic [3:0]            nib;
  logic [6:0]            seg7;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] an_show;
  logic                  lit;
  logic                  frame_end;

  assign frame_end  = (state == SHOW) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign accept     = value_valid && value_ready;
  assign pend_f_nxt = accept || (pend_f && !frame_end);

  // Single shared decoder fed by the nibble of the digit currently scanned.
  assign nib = disp_q[idx];

  seg_hex_decode u_dec (
    .nibble (nib),
    .seg7   (seg7)
  );

  // Leading-zero mask: digit i is suppressed when nibbles i..top are all zero.
  always_comb begin
    lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin : g_lz
      logic zero_above;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        zero_above = zero_above && (disp_q[i] == 4'h0);
        lz[i] = zero_above;
      end
    end
`endif
  end

  // One-hot-low anode pattern for the current digit.
  always_comb begin
    an_show      = '1;
    an_show[idx] = 1'b0;
  end

  assign lit = (state == SHOW) && digit_en[idx] && !lz[idx];

  // Scan FSM, slot counter, digit index and registered an/seg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
      an    <= '1;
      seg   <= SEG_BLANK;
    end else begin
      an  <= lit ? an_show : '1;
      seg <= lit ? {~dp_in[idx], seg7} : SEG_BLANK;
      case (state)
        BLANK: begin
          if (GUARD_CYCLES == 0) begin
            state <= SHOW;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_GLAST) state <= SHOW;
          end
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (GUARD_CYCLES == 0) state <= SHOW;
            else                   state <= BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  // Handshake: stage accepted words, commit to the display at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q      <= '0;
      pend_q      <= '0;
      pend_f      <= 1'b0;
      value_ready <= 1'b0;
    end else begin
      if (frame_end && pend_f) disp_q <= pend_q;
      if (accept)              pend_q <= value;
      pend_f      <= pend_f_nxt;
      value_ready <= !pend_f_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 guard cycles).
// Expected an/seg/ready come from a timeline model: edge n after reset release
// scans digit (n/8)%4 at slot position n%8, frames end at n%32 == 31.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [7:0]  seg;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  int          m_n = 0;
  bit          m_pend = 0;
  bit          m_rdy = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pval = '0;
  bit          dut_acc = 0;

  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h (n=%0d)", tag, obs, exp, m_n);
    end
  endtask

  // One clock: predict outputs for this edge, advance the model, then check.
  task automatic tick();
    int         pos, d;
    logic [3:0] nib;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    bit         lit, e_rdy, acc;
    if (rst) begin
      e_an = 4'hF; e_seg = 8'hFF; e_rdy = 0;
      m_n = 0; m_pend = 0; m_rdy = 0; m_disp = '0; m_pval = '0;
      dut_acc = 0;
    end else begin
      pos = m_n % RD;
      d   = (m_n / RD) % ND;
      nib = m_disp[4*d +: 4];
      lit = (pos >= GC) && digit_en[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (m_disp >> (4*d)) == 16'h0) lit = 0;
`endif
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_seg = lit ? {~dp_in[d], tbl[nib][6:0]} : 8'hFF;
      acc = value_valid && m_rdy;
      dut_acc = value_valid && value_ready;
      if ((m_n % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_pval;
        m_pend = 0;
      end
      if (acc) begin
        m_pval = value;
        m_pend = 1;
      end
      m_rdy = !m_pend;
      e_rdy = m_rdy;
      m_n++;
    end
    @(posedge clk);
    #1;
    check("an", {4'h0, an}, {4'h0, e_an});
    check("seg", seg, e_seg);
    check("ready", {7'h0, value_ready}, {7'h0, e_rdy});
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Offer a word and hold it until the DUT takes it (bounded).
  task automatic send(input logic [15:0] w);
    int k;
    k = 0;
    value = w;
    value_valid = 1'b1;
    do begin
      tick();
      k++;
    end while (!dut_acc && k < 4 * FRAME);
    compared++;
    assert (dut_acc) else begin
      mismatched++;
      $error("FAIL accept_timeout observed=0 expected=1 word=%h", w);
    end
    value_valid = 1'b0;
  endtask

  initial begin
    // Reset held three cycles, then release: first lit digit appears 3 cycles later.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(12);

    // Single load, all digits enabled.
    send(16'h1A2F);
    run(2 * FRAME + 6);

    // Back-to-back loads: second word waits for the boundary.
    send(16'h1111);
    send(16'h2222);
    run(2 * FRAME + 6);

    // Sparse enables with a decimal point on digit 0.
    digit_en = 4'b0101;
    dp_in    = 4'b0001;
    run(FRAME + 4);
    digit_en = 4'hF;
    dp_in    = 4'h0;

    // Randomized producer, enables and decimal points.
    for (int i = 0; i < 400; i++) begin
      if (value_valid && dut_acc) value_valid = 1'b0;
      if (!value_valid && ($urandom % 6) == 0) begin
        value       = 16'($urandom);
        value_valid = 1'b1;
      end
      if ((i % 16) == 0) digit_en = 4'($urandom);
      dp_in = 4'($urandom);
      tick();
    end
    value_valid = 1'b0;
    digit_en    = 4'hF;
    dp_in       = 4'h0;
    run(FRAME + 2);

    // Leading-zero patterns (blanked only when the option is built in).
    send(16'h0030);
    run(2 * FRAME);
    send(16'h0000);
    run(2 * FRAME);
    send(16'h4006);
    run(2 * FRAME);

    // Reset mid-SHOW of digit 2 while a word is pending.
    for (int k = 0; k < 2 * FRAME && (m_n % FRAME) != 0; k++) tick();
    send(16'h5555);
    for (int k = 0; k < 2 * FRAME && (m_n % FRAME) != 2 * RD + 4; k++) tick();
    compared++;
    assert (m_pend && (m_n % FRAME) == 2 * RD + 4 && !value_ready) else begin
      mismatched++;
      $error("FAIL pending_before_reset observed=%0d expected=%0d", m_n % FRAME, 2 * RD + 4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(2 * FRAME + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
